mfcc_frame_sched: RTL and testbench

MFCC_FRAME_SCHED -- requirements
Module: mfcc_frame_sched

---
 rtl/mfcc_frame_sched.sv | 205 ++++++++++++++++++++
 tb/tb_mfcc_frame_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_sched.sv
// MFCC frame scheduler: counts audio samples into overlapping frames and
// walks each frame through the window/periodogram/mel/log/dct stages.
module mfcc_frame_sched #(
    parameter int FRAME_LEN  = 256,
    parameter int HOP_LEN    = 128,
    parameter int NUM_STAGES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sample_valid,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  busy,
    output logic                  mfcc_valid,
    output logic [15:0]           frame_count,
    output logic                  overrun
);

    localparam logic [15:0] FRAME_THR = 16'(FRAME_LEN);
    localparam logic [15:0] HOP_THR   = 16'(HOP_LEN);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_S4   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [15:0]             count_r;
    logic [15:0]             threshold_s;
    logic                    primed_r;
    logic                    count_en_s;
    logic                    frame_event_s;
    logic                    pending_r;
    logic                    pending_next_s;
    logic                    consume_s;
    logic                    direct_s;
    logic                    drop_s;
    logic                    overrun_r;
    logic                    busy_r;
    logic                    mfcc_valid_r;
    logic [15:0]             frame_count_r;
    logic [NUM_STAGES-1:0]   stage_start_r;
    logic [NUM_STAGES-1:0]   start_next_s;

    // Sample-counter decode: active threshold and frame-event detection.
    always_comb begin
        count_en_s = sample_valid & enable;
        if (primed_r) begin
            threshold_s = HOP_THR;
        end else begin
            threshold_s = FRAME_THR;
        end
        frame_event_s = count_en_s & ((count_r + 16'd1) == threshold_s);
    end

    // Sample counter and primed flag; the counter restarts on every frame event.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= 16'd0;
            primed_r <= 1'b0;
        end else if (frame_event_s) begin
            count_r  <= 16'd0;
            primed_r <= 1'b1;
        end else if (count_en_s) begin
            count_r  <= count_r + 16'd1;
        end else begin
            count_r  <= count_r;
            primed_r <= primed_r;
        end
    end

    // Next-state decode; a stage start is issued only on entry into its state.
    always_comb begin
        next_state_s = state_r;
        start_next_s = 5'b00000;
        case (state_r)
            ST_IDLE: begin
                if (enable && (frame_event_s || pending_r)) begin
                    next_state_s = ST_S0;
                    start_next_s = 5'b00001;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_S0: begin
                if (stage_done[0]) begin
                    next_state_s = ST_S1;
                    start_next_s = 5'b00010;
                end else begin
                    next_state_s = ST_S0;
                end
            end
            ST_S1: begin
                if (stage_done[1]) begin
                    next_state_s = ST_S2;
                    start_next_s = 5'b00100;
                end else begin
                    next_state_s = ST_S1;
                end
            end
            ST_S2: begin
                if (stage_done[2]) begin
                    next_state_s = ST_S3;
                    start_next_s = 5'b01000;
                end else begin
                    next_state_s = ST_S2;
                end
            end
            ST_S3: begin
                if (stage_done[3]) begin
                    next_state_s = ST_S4;
                    start_next_s = 5'b10000;
                end else begin
                    next_state_s = ST_S3;
                end
            end
            ST_S4: begin
                if (stage_done[4]) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_S4;
                end
            end
            ST_DONE: begin
                if (pending_r && enable) begin
                    next_state_s = ST_S0;
                    start_next_s = 5'b00001;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                start_next_s = 5'b00000;
            end
        endcase
    end

    // One-deep event queue: an event is taken directly only by an idle, empty
    // scheduler; a full slot that is not being drained this cycle loses it.
    always_comb begin
        consume_s      = pending_r & enable & ((state_r == ST_IDLE) | (state_r == ST_DONE));
        direct_s       = frame_event_s & (state_r == ST_IDLE) & ~pending_r;
        pending_next_s = pending_r;
        drop_s         = 1'b0;
        if (frame_event_s) begin
            if (direct_s) begin
                pending_next_s = 1'b0;
            end else begin
                pending_next_s = 1'b1;
                drop_s         = pending_r & ~consume_s;
            end
        end else if (consume_s) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // State register and registered FSM outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            stage_start_r <= 5'b00000;
            busy_r        <= 1'b0;
            mfcc_valid_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r       <= next_state_s;
            stage_start_r <= start_next_s;
            busy_r        <= (next_state_s != ST_IDLE);
            mfcc_valid_r  <= (next_state_s == ST_DONE);
            if (next_state_s == ST_DONE) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    // Pending slot and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            overrun_r <= overrun_r | drop_s;
        end
    end

    assign stage_start = stage_start_r;
    assign busy        = busy_r;
    assign mfcc_valid  = mfcc_valid_r;
    assign frame_count = frame_count_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_mfcc_frame_sched.sv
// Scoreboard bench for mfcc_frame_sched: a frame-level reference model predicts
// stage starts, DONE pulses and per-cycle status; a monitor compares them.
module tb_mfcc_frame_sched;

    localparam int FL = 8;
    localparam int HL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [4:0]  stage_start;
    logic [4:0]  stage_done;
    logic [4:0]  resp_done = 5'b00000;
    logic [4:0]  inj_done = 5'b00000;
    logic        busy;
    logic        mfcc_valid;
    logic [15:0] frame_count;
    logic        overrun;

    assign stage_done = resp_done | inj_done;

    mfcc_frame_sched #(.FRAME_LEN(FL), .HOP_LEN(HL), .NUM_STAGES(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .stage_start(stage_start), .stage_done(stage_done), .busy(busy),
        .mfcc_valid(mfcc_valid), .frame_count(frame_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [4:0] start; logic mv; logic [15:0] fc; } ev_t;
    typedef struct { int cyc; logic busy; logic ovr; logic [15:0] fc; } st_t;
    ev_t exp_q[$];
    st_t st_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // reference model state: sample phase, one-deep event slot, frame in flight
    int m_cnt = 0, m_fc = 0, m_s0 = 0, m_done = 0, m_idx = 0;
    bit m_primed = 1'b0, m_pend = 1'b0, m_ovr = 1'b0, m_run = 1'b0;
    int lat_tab [0:20479];
    bit use_force = 1'b0;
    int force_lat [5];
    int cur_t = 0;
    int inj_at = -1;
    logic [4:0] inj_val = 5'b00000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rand_lat();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(10, 30));
        return int'($urandom_range(0, 4));
    endfunction

    // Predict everything visible from cycle t+1 given the inputs of cycle t.
    task automatic model(input int t, input logic en, input logic sv, input logic rs);
        int thr, c, lat;
        bit idle, in_done, ev, launch, freed;
        ev_t e;
        st_t s;
        ev_t keep_q[$];
        if (rs) begin
            m_cnt = 0; m_primed = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
            m_fc = 0; m_run = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].cyc <= t) keep_q.push_back(exp_q[i]);
            exp_q = keep_q;
        end else begin
            thr     = m_primed ? HL : FL;
            idle    = !(m_run && t <= m_done);
            in_done = m_run && (t == m_done);
            ev      = en && sv && (m_cnt + 1 == thr);
            if (en && sv) begin
                if (ev) begin m_cnt = 0; m_primed = 1'b1; end
                else m_cnt = m_cnt + 1;
            end
            launch = en && ((idle && (ev || m_pend)) || (in_done && m_pend));
            freed  = launch && m_pend;
            if (freed) m_pend = 1'b0;
            if (ev && !(launch && !freed)) begin
                if (m_pend) m_ovr = 1'b1;
                else m_pend = 1'b1;
            end
            if (launch) begin
                m_s0 = t + 1;
                c = m_s0;
                for (int k = 0; k < 5; k++) begin
                    lat = use_force ? force_lat[k] : rand_lat();
                    lat_tab[(m_idx % 4096) * 5 + k] = lat;
                    e.cyc = c; e.start = 5'(1 << k); e.mv = 1'b0; e.fc = 16'(m_fc);
                    exp_q.push_back(e);
                    c = c + lat + 1;
                end
                e.cyc = c; e.start = 5'b00000; e.mv = 1'b1; e.fc = 16'(m_fc + 1);
                exp_q.push_back(e);
                m_fc   = m_fc + 1;
                m_done = c;
                m_run  = 1'b1;
                m_idx  = m_idx + 1;
            end
        end
        s.cyc  = t + 1;
        s.busy = m_run && (t + 1 <= m_done);
        s.ovr  = m_ovr;
        s.fc   = 16'(m_fc - ((m_run && m_done > t + 1) ? 1 : 0));
        st_q.push_back(s);
    endtask

    task automatic step(input logic en, input logic sv, input logic rs);
        @(negedge clk);
        enable = en;
        sample_valid = sv;
        rst = rs;
        cur_t = cyc;
        inj_done = (cur_t == inj_at) ? inj_val : 5'b00000;
        model(cur_t, en, sv, rs);
    endtask

    // Stage responder: answers stage_start[k] with stage_done[k] after the
    // latency the model chose for that frame (0 = same cycle).
    int rem [5] = '{-1, -1, -1, -1, -1};
    int r_cnt = 0, r_cur = 0;
    logic [4:0] nd;
    always @(negedge clk) begin
        nd = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
                if (rem[k] == 0) begin nd[k] = 1'b1; rem[k] = -1; end
            end
        end
        if (stage_start[0] === 1'b1) begin r_cur = r_cnt; r_cnt = r_cnt + 1; end
        for (int k = 0; k < 5; k++) begin
            if (stage_start[k] === 1'b1) begin
                if (lat_tab[(r_cur % 4096) * 5 + k] == 0) nd[k] = 1'b1;
                else rem[k] = lat_tab[(r_cur % 4096) * 5 + k];
            end
        end
        resp_done = nd;
    end

    // Monitor: per-cycle status plus every start/DONE output against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                chk("busy", 32'(busy), 32'(st_q[0].busy));
                chk("overrun", 32'(overrun), 32'(st_q[0].ovr));
                chk("frame_count", 32'(frame_count), 32'(st_q[0].fc));
                void'(st_q.pop_front());
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++; n_err++;
                $display("FAIL missed_output @cycle %0d: got nothing, expected start=%b mfcc_valid=%b at cycle %0d",
                         cyc, exp_q[0].start, exp_q[0].mv, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (stage_start !== 5'b00000 || mfcc_valid !== 1'b0) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    chk("stage_start", 32'(stage_start), 32'(exp_q[0].start));
                    chk("mfcc_valid", 32'(mfcc_valid), 32'(exp_q[0].mv));
                    chk("done_frame_count", 32'(frame_count), 32'(exp_q[0].fc));
                    void'(exp_q.pop_front());
                end else begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output @cycle %0d: got start=%b mfcc_valid=%b, expected none",
                             cyc, stage_start, mfcc_valid);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus, expected completion");
        $fatal(1);
    end

    initial begin
        step(1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {stage_start, busy, mfcc_valid, overrun, frame_count}, 32'd0);

        // first frame after 8 samples, stages answered 3 cycles after each start
        use_force = 1'b1;
        force_lat = '{3, 3, 3, 3, 3};
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);
        // hop frame after 4 samples
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);

        // stall stage 2 while two more events arrive
        force_lat = '{1, 1, 40, 1, 1};
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (130) step(1'b1, 1'b0, 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // foreign done bits in S1 and in IDLE
        force_lat = '{3, 3, 3, 3, 3};
        repeat (4) step(1'b1, 1'b1, 1'b0);
        inj_at = m_s0 + 5;
        inj_val = 5'b10000;
        repeat (30) step(1'b1, 1'b0, 1'b0);
        inj_at = cur_t + 3;
        inj_val = 5'b00001;
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // reset while in S3; the next frame needs a full 8 samples again
        repeat (4) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 50 && cur_t < m_s0 + 12; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0);

        // randomized traffic, enable toggling and stage latencies
        use_force = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0), 1'b0);
        end
        repeat (400) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
